// File: rtl/servo_update_scheduler.sv
// -----------------------------------------------------------------------------
// servo_update_scheduler
//
// Shares the servo controller's duty-cycle write port between four command
// requesters and paces the writes to the servo frame rate. Commands are
// arbitrated round-robin into per-servo shadow registers. Once per frame every
// servo with a pending command is written out in address order, one servo per
// cycle.
//
// Parameters:
//   CLOCK_FREQ  clock frequency in Hz
//   FRAME_HZ    update frame rate; FRAME_CYCLES = CLOCK_FREQ/FRAME_HZ (>= 8)
//   MAX_DUTY    upper clamp applied to accepted duty values
//
// Ports:
//   clock              system clock, rising edge
//   reset              synchronous, active-high reset
//   req_valid[3:0]     command valid, one bit per requester
//   req_address[7:0]   2-bit servo address per requester (req i: [2i+1:2i])
//   req_duty[31:0]     8-bit duty per requester (req i: [8i+7:8i])
//   req_ready[3:0]     one-hot grant; accept = req_valid[i] & req_ready[i]
//   servo_address[1:0] target servo of the current write
//   switch_duty_cycle  duty value of the current write
//   servo_wr           one-cycle write strobe to the servo controller
//   frame_tick         one-cycle pulse at each frame boundary
// -----------------------------------------------------------------------------
module servo_update_scheduler #(
   parameter int         CLOCK_FREQ = 50000000,
   parameter int         FRAME_HZ   = 50,
   parameter logic [7:0] MAX_DUTY   = 8'd200
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [3:0]  req_valid,
   input  logic [7:0]  req_address,
   input  logic [31:0] req_duty,
   output logic [3:0]  req_ready,
   output logic [1:0]  servo_address,
   output logic [7:0]  switch_duty_cycle,
   output logic        servo_wr,
   output logic        frame_tick
);

   localparam int FRAME_CYCLES = CLOCK_FREQ / FRAME_HZ;
   localparam int CNT_W        = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_CYCLES - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      FLUSH = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [1:0]       idx_q, idx_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       ptr_q, ptr_d;
   logic [3:0]       pending_q, pending_d;
   logic [7:0]       shadow_q [4];
   logic [7:0]       shadow_d [4];
   logic [1:0]       servo_address_q, servo_address_d;
   logic [7:0]       duty_q, duty_d;
   logic             servo_wr_q, servo_wr_d;
   logic             frame_tick_q, frame_tick_d;

   // Arbiter results
   logic [3:0] grant;
   logic [1:0] grant_idx;
   logic       grant_found;
   logic [1:0] cand;

   // Accepted command fields (valid only when grant_found)
   logic [1:0] acc_addr;
   logic [7:0] acc_duty;
   logic [7:0] acc_duty_clamped;
   logic       wrap;

   // --------------------------------------------------------------------------
   // Round-robin arbiter: first asserted req_valid at or after the pointer.
   // Grants only in IDLE and never in a reset cycle.
   // --------------------------------------------------------------------------
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned, which would otherwise infer a latch.
      grant       = '0;
      grant_idx   = ptr_q;
      grant_found = 1'b0;
      cand        = '0;
      if ((state_q == IDLE) && !reset) begin
         for (int j = 0; j < 4; j++) begin
            cand = ptr_q + 2'(j);   // 2-bit add wraps mod 4
            if (!grant_found && req_valid[cand]) begin
               grant[cand] = 1'b1;
               grant_idx   = cand;
               grant_found = 1'b1;
            end
         end
      end
   end

   assign req_ready = grant;

   assign acc_addr         = req_address[{grant_idx, 1'b0} +: 2];
   assign acc_duty         = req_duty[{grant_idx, 3'b000} +: 8];
   assign acc_duty_clamped = (acc_duty > MAX_DUTY) ? MAX_DUTY : acc_duty;
   assign wrap             = (cnt_q == CNT_LAST);

   // --------------------------------------------------------------------------
   // Next-state logic: frame counter, command capture and flush sequencing.
   // --------------------------------------------------------------------------
   always_comb begin
      state_d         = state_q;
      idx_d           = idx_q;
      ptr_d           = ptr_q;
      pending_d       = pending_q;
      shadow_d        = shadow_q;
      servo_address_d = servo_address_q;
      duty_d          = duty_q;
      servo_wr_d      = 1'b0;
      frame_tick_d    = 1'b0;

      // Free-running frame counter, also counting through FLUSH
      cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);

      unique case (state_q)
         IDLE: begin
            if (grant_found) begin
               shadow_d[acc_addr]  = acc_duty_clamped;  // latest command wins
               pending_d[acc_addr] = 1'b1;
               ptr_d               = grant_idx + 2'd1;
            end
            // Accept in the wrap cycle and flush entry coincide: the command
            // accepted here is already pending when idx 0 is examined.
            if (wrap) begin
               state_d      = FLUSH;
               idx_d        = 2'd0;
               frame_tick_d = 1'b1;
            end
         end

         FLUSH: begin
            // Write only servos with a pending command; otherwise the address
            // and duty outputs keep their last written values.
            if (pending_q[idx_q]) begin
               servo_address_d    = idx_q;
               duty_d             = shadow_q[idx_q];
               servo_wr_d         = 1'b1;
               pending_d[idx_q]   = 1'b0;
            end
            idx_d = idx_q + 2'd1;
            if (idx_q == 2'd3) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // --------------------------------------------------------------------------
   // State registers
   // --------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge values, independent of statement order.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q         <= IDLE;
         idx_q           <= '0;
         cnt_q           <= '0;
         ptr_q           <= '0;
         pending_q       <= '0;
         // NOTE: the shadow array is explicitly reset because its contents are
         // part of the defined reset state; it is only four bytes of flops.
         for (int i = 0; i < 4; i++) begin
            shadow_q[i] <= '0;
         end
         servo_address_q <= '0;
         duty_q          <= '0;
         servo_wr_q      <= 1'b0;
         frame_tick_q    <= 1'b0;
      end else begin
         state_q         <= state_d;
         idx_q           <= idx_d;
         cnt_q           <= cnt_d;
         ptr_q           <= ptr_d;
         pending_q       <= pending_d;
         shadow_q        <= shadow_d;
         servo_address_q <= servo_address_d;
         duty_q          <= duty_d;
         servo_wr_q      <= servo_wr_d;
         frame_tick_q    <= frame_tick_d;
      end
   end

   assign servo_address     = servo_address_q;
   assign switch_duty_cycle = duty_q;
   assign servo_wr          = servo_wr_q;
   assign frame_tick        = frame_tick_q;

endmodule
